serial_to_unfolded3: RTL and testbench

//   Upstream stage of the 3-unfolded pipelined FIR. Gathers a serial, valid-qualified

---
 rtl/serial_to_unfolded3.sv | 111 +++++++++++
 tb/tb_serial_to_unfolded3.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_to_unfolded3.sv
// Packs a valid-qualified serial sample stream into groups of three for the
// 3-unfolded FIR, with FLUSH closing a partial group using zero fill.
module serial_to_unfolded3 #(
    parameter int NBIT = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBIT-1:0] DIN,
    input  logic            VIN,
    input  logic            FLUSH,
    output logic [NBIT-1:0] DOUT3k,
    output logic [NBIT-1:0] DOUT3k1,
    output logic [NBIT-1:0] DOUT3k2,
    output logic            VOUT,
    output logic            PADDED
);

    // State names give the number of samples already held for the open group.
    typedef enum logic [1:0] {
        HOLD0 = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } phase_t;

    phase_t          phase_r;
    logic [NBIT-1:0] h0_r;
    logic [NBIT-1:0] h1_r;
    logic [NBIT-1:0] zero_s;

    assign zero_s = {NBIT{1'b0}};

    // Group assembly FSM; a same-cycle VIN sample is absorbed before FLUSH closes the group.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_r <= HOLD0;
            h0_r    <= {NBIT{1'b0}};
            h1_r    <= {NBIT{1'b0}};
            DOUT3k  <= {NBIT{1'b0}};
            DOUT3k1 <= {NBIT{1'b0}};
            DOUT3k2 <= {NBIT{1'b0}};
            VOUT    <= 1'b0;
            PADDED  <= 1'b0;
        end else if (FLUSH) begin
            phase_r <= HOLD0;
            case (phase_r)
                HOLD0: begin
                    if (VIN) begin
                        DOUT3k  <= DIN;
                        DOUT3k1 <= zero_s;
                        DOUT3k2 <= zero_s;
                        VOUT    <= 1'b1;
                        PADDED  <= 1'b1;
                    end else begin
                        VOUT    <= 1'b0;
                        PADDED  <= 1'b0;
                    end
                end
                HOLD1: begin
                    DOUT3k  <= h0_r;
                    DOUT3k1 <= VIN ? DIN : zero_s;
                    DOUT3k2 <= zero_s;
                    VOUT    <= 1'b1;
                    PADDED  <= 1'b1;
                end
                HOLD2: begin
                    DOUT3k  <= h0_r;
                    DOUT3k1 <= h1_r;
                    DOUT3k2 <= VIN ? DIN : zero_s;
                    VOUT    <= 1'b1;
                    PADDED  <= ~VIN;
                end
                default: begin
                    VOUT    <= 1'b0;
                    PADDED  <= 1'b0;
                end
            endcase
        end else if (VIN) begin
            case (phase_r)
                HOLD0: begin
                    h0_r    <= DIN;
                    phase_r <= HOLD1;
                    VOUT    <= 1'b0;
                    PADDED  <= 1'b0;
                end
                HOLD1: begin
                    h1_r    <= DIN;
                    phase_r <= HOLD2;
                    VOUT    <= 1'b0;
                    PADDED  <= 1'b0;
                end
                HOLD2: begin
                    DOUT3k  <= h0_r;
                    DOUT3k1 <= h1_r;
                    DOUT3k2 <= DIN;
                    phase_r <= HOLD0;
                    VOUT    <= 1'b1;
                    PADDED  <= 1'b0;
                end
                default: begin
                    phase_r <= HOLD0;
                    VOUT    <= 1'b0;
                    PADDED  <= 1'b0;
                end
            endcase
        end else begin
            VOUT   <= 1'b0;
            PADDED <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_unfolded3.sv
// Directed and scoreboard-driven bench for serial_to_unfolded3.
module tb_serial_to_unfolded3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       VIN = 1'b0;
    logic       FLUSH = 1'b0;
    logic [7:0] DOUT3k;
    logic [7:0] DOUT3k1;
    logic [7:0] DOUT3k2;
    logic       VOUT;
    logic       PADDED;

    int checks = 0;
    int errors = 0;

    serial_to_unfolded3 #(.NBIT(8)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .FLUSH(FLUSH),
        .DOUT3k(DOUT3k), .DOUT3k1(DOUT3k1), .DOUT3k2(DOUT3k2),
        .VOUT(VOUT), .PADDED(PADDED)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic v, input logic [7:0] d, input logic f);
        VIN = v;
        DIN = d;
        FLUSH = f;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic p,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {VOUT, PADDED, DOUT3k, DOUT3k1, DOUT3k2};
        exp = {v, p, a, b, c};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (vout,padded,d0,d1,d2)", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] ea, eb, ec;
        logic [7:0] d;
        logic       v;
        logic       ev;
        int         accepted;
        int         vout_seen;

        // reset
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b1);
        expect_out("reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        RST = 1'b0;

        // 1: six back-to-back samples
        step(1'b1, 8'd1, 1'b0); expect_out("t1_c2", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'd2, 1'b0); expect_out("t1_c3", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'd3, 1'b0); expect_out("t1_c4", 1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
        step(1'b1, 8'd4, 1'b0); expect_out("t1_c5", 1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
        step(1'b1, 8'd5, 1'b0); expect_out("t1_c6", 1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
        step(1'b1, 8'd6, 1'b0); expect_out("t1_c7", 1'b1, 1'b0, 8'd4, 8'd5, 8'd6);
        step(1'b0, 8'd0, 1'b0); expect_out("t1_drop", 1'b0, 1'b0, 8'd4, 8'd5, 8'd6);

        // 2: gapped samples after a fresh reset
        RST = 1'b1; step(1'b0, 8'h00, 1'b0); RST = 1'b0;
        expect_out("t2_reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'h10, 1'b0); step(1'b0, 8'hEE, 1'b0);
        expect_out("t2_gap1", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'hEE, 1'b0); step(1'b1, 8'h20, 1'b0);
        expect_out("t2_second", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'hEE, 1'b0); step(1'b0, 8'hEE, 1'b0);
        expect_out("t2_gap2", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'h30, 1'b0); expect_out("t2_group", 1'b1, 1'b0, 8'h10, 8'h20, 8'h30);
        step(1'b0, 8'hEE, 1'b0); expect_out("t2_hold", 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);

        // 3: flush with one held sample
        step(1'b1, 8'h7F, 1'b0); expect_out("t3_accept", 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        step(1'b0, 8'hEE, 1'b1); expect_out("t3_flush", 1'b1, 1'b1, 8'h7F, 8'h00, 8'h00);

        // 4: flush with a same-cycle sample; count 3, count 2 and count 0 flushes
        step(1'b1, 8'h80, 1'b0); expect_out("t4_accept", 1'b0, 1'b0, 8'h7F, 8'h00, 8'h00);
        step(1'b1, 8'h81, 1'b1); expect_out("t4_flush2", 1'b1, 1'b1, 8'h80, 8'h81, 8'h00);
        step(1'b0, 8'hEE, 1'b0); expect_out("t4_idle", 1'b0, 1'b0, 8'h80, 8'h81, 8'h00);
        step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b1); expect_out("t4_flush3", 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
        step(1'b1, 8'h44, 1'b0); expect_out("t4_after3", 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'hEE, 1'b1); expect_out("t4_flushp2", 1'b1, 1'b1, 8'h44, 8'h55, 8'h00);
        step(1'b0, 8'hEE, 1'b1); expect_out("t4_flush0", 1'b0, 1'b0, 8'h44, 8'h55, 8'h00);
        step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0); expect_out("t4_slot3k", 1'b1, 1'b0, 8'h01, 8'h02, 8'h03);

        // 5: reset discards a partial group
        step(1'b1, 8'hA1, 1'b0); step(1'b1, 8'hA2, 1'b0);
        RST = 1'b1; step(1'b1, 8'hA3, 1'b1); RST = 1'b0;
        expect_out("t5_reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'hB1, 1'b0); expect_out("t5_a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'hB2, 1'b0); expect_out("t5_b", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'hB3, 1'b0); expect_out("t5_c", 1'b1, 1'b0, 8'hB1, 8'hB2, 8'hB3);

        // 6: random gapped stream against a queue model
        ea = 8'hB1; eb = 8'hB2; ec = 8'hB3;
        accepted = 0;
        vout_seen = 0;
        for (int cyc = 0; cyc < 3000 && accepted < 300; cyc++) begin
            v = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            step(v, d, 1'b0);
            ev = 1'b0;
            if (v) begin
                q.push_back(d);
                accepted++;
                if (q.size() == 3) begin
                    ea = q[0]; eb = q[1]; ec = q[2];
                    q.delete();
                    ev = 1'b1;
                end
            end
            if (VOUT === 1'b1) vout_seen++;
            expect_out("t6_stream", ev, 1'b0, ea, eb, ec);
        end
        checks++;
        assert (vout_seen == 100) else begin
            errors++;
            $error("FAIL t6_vout_count observed=%0d expected=%0d", vout_seen, 100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
